load_store_unit: RTL and testbench

Parametrised load/store unit between the core datapath and data memory. It replaces the fixed full-word, single-cycle data-memory access with a multi-cycle request/acknowledge handshake, which lets memory insert wait states. It adds RV sub-word access (byte/half/word, plus double when XLEN=64), per-byte write strobes, load sign/zero extension, misalignment and illegal-func3 detection, and a bus timeout. The datapath holds its PC and pipeline state while `stall` is high and retires the access on `resp_valid`.

---
 rtl/load_store_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Sits between the core datapath and data memory. Converts a datapath
//   load/store request into a multi-cycle mem_req/mem_ack transaction. It
//   handles RV sub-word accesses (byte/half/word, plus double when XLEN=64),
//   per-byte write strobes, load sign/zero extension, misalignment and
//   illegal-func3 detection, and a bus timeout.
//
//   Handshake: a request is taken on a rising edge where req_valid=1 and
//   req_ready=1 (the unit is IDLE). Exactly one resp_valid pulse follows each
//   accepted request, except when rst cuts the access short. stall stays high
//   from the request until the response cycle. The memory side holds mem_req
//   and all mem_* fields stable until mem_ack=1 or the timeout expires.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake from the datapath
//   req_store, req_func3     access kind and RV funct3 width/sign code
//   req_addr, req_wdata      byte address and store data
//   req_rd                   destination tag, returned on resp_rd
//   resp_valid               one-cycle completion pulse
//   resp_rdata               extended load data (0 for stores and faults)
//   resp_rd                  tag of the completed access
//   resp_fault               illegal func3 or bus timeout
//   resp_misaligned          address not aligned to the access size
//   stall                    datapath must hold its state
//   mem_req/mem_we           memory request and write enable
//   mem_addr                 word-aligned address
//   mem_wdata, mem_strb      lane-replicated store data and byte strobes
//   mem_ack, mem_rdata       memory completion and read data
//   dbg_state                current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
module load_store_unit #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_func3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_fault,
  output logic              resp_misaligned,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_strb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              store_q;
  logic [2:0]        func3_q;
  logic [OFF_W-1:0]  off_q;
  logic [XLEN-1:0]   maddr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [4:0]        rd_q;
  logic [7:0]        cnt_q;
  logic [XLEN-1:0]   rdata_q;
  logic              fault_q;
  logic              mis_q;

  // Request decode (combinational, used only on acceptance)
  logic              legal_c;
  logic              mis_c;
  logic [OFF_W-1:0]  off_c;
  logic [STRB_W-1:0] strb_c;
  logic [XLEN-1:0]   wdata_c;

  assign off_c = req_addr[OFF_W-1:0];

  always_comb begin
    legal_c = 1'b0;
    case (req_func3)
      3'b000, 3'b001, 3'b010: legal_c = 1'b1;
      3'b011:                 legal_c = (XLEN == 64);
      3'b100, 3'b101:         legal_c = !req_store;
      3'b110:                 legal_c = !req_store && (XLEN == 64);
      default:                legal_c = 1'b0;
    endcase
  end

  // Low two funct3 bits encode the access size for every legal code.
  always_comb begin
    mis_c   = 1'b0;
    strb_c  = '1;
    wdata_c = req_wdata;
    case (req_func3[1:0])
      2'b00: begin
        strb_c  = STRB_W'(1) << off_c;
        wdata_c = {STRB_W{req_wdata[7:0]}};
      end
      2'b01: begin
        mis_c   = off_c[0];
        strb_c  = STRB_W'(3) << off_c;
        wdata_c = {(XLEN/16){req_wdata[15:0]}};
      end
      2'b10: begin
        mis_c   = (off_c[1:0] != 2'b00);
        strb_c  = STRB_W'(15) << off_c;
        wdata_c = {(XLEN/32){req_wdata[31:0]}};
      end
      default: begin
        mis_c   = (off_c != '0);
        strb_c  = '1;
        wdata_c = req_wdata;
      end
    endcase
    // An illegal code reports only the fault, never misalignment.
    if (!legal_c) mis_c = 1'b0;
  end

  // Load lane extraction and sign/zero extension
  logic [XLEN-1:0] shifted_c;
  logic [XLEN-1:0] load_ext_c;
  int              lane_bits;
  logic            sign_bit;

  assign shifted_c = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (func3_q[1:0])
      2'b00:   lane_bits = 8;
      2'b01:   lane_bits = 16;
      2'b10:   lane_bits = 32;
      default: lane_bits = XLEN;
    endcase
    // funct3[2]=1 selects the unsigned variants.
    sign_bit   = !func3_q[2] && shifted_c[lane_bits-1];
    load_ext_c = '0;
    for (int i = 0; i < XLEN; i++) begin
      load_ext_c[i] = (i < lane_bits) ? shifted_c[i] : sign_bit;
    end
  end

  // FSM
  logic accept;
  logic timeout;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (!legal_c || mis_c) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = RESP;
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          // This is the TIMEOUT_CYC-th cycle without an ack.
          timeout = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q <= 1'b0;
      func3_q <= '0;
      off_q   <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (accept) begin
      store_q <= req_store;
      func3_q <= req_func3;
      off_q   <= off_c;
      maddr_q <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
      wdata_q <= wdata_c;
      strb_q  <= req_store ? strb_c : '1;
      rd_q    <= req_rd;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= !legal_c;
      mis_q   <= mis_c;
    end else if (state_q == ACCESS) begin
      if (mem_ack) begin
        if (!store_q) rdata_q <= load_ext_c;
      end else if (timeout) begin
        fault_q <= 1'b1;
        rdata_q <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Outputs
  assign req_ready       = (state_q == IDLE);
  assign stall           = ((state_q == IDLE) && req_valid) || (state_q == ACCESS);
  assign mem_req         = (state_q == ACCESS);
  assign mem_we          = (state_q == ACCESS) && store_q;
  assign mem_addr        = maddr_q;
  assign mem_wdata       = wdata_q;
  assign mem_strb        = strb_q;
  assign resp_valid      = (state_q == RESP);
  assign resp_rdata      = rdata_q;
  assign resp_rd         = rd_q;
  assign resp_fault      = (state_q == RESP) && fault_q;
  assign resp_misaligned = (state_q == RESP) && mis_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit (XLEN=32, TIMEOUT_CYC=4).
module tb_load_store_unit;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_func3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_fault;
  logic              resp_misaligned;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_strb;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;
  logic [1:0]        dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  load_store_unit #(.XLEN(XLEN), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_fault(resp_fault), .resp_misaligned(resp_misaligned),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: present a request; the following edge accepts it.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1;
    req_store = st;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    #1;
    check_eq("stall_on_req", stall, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  // Called in the first ACCESS cycle: waits 'waits' cycles, then acks.
  // Returns in the RESP cycle.
  task automatic ack_after(input int waits, input logic [31:0] rdata);
    for (int i = 0; i < waits; i++) begin
      check_eq("wait_mem_req", mem_req, 1'b1);
      step();
    end
    check_eq("ack_mem_req", mem_req, 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] rdata, input logic [4:0] rd,
                            input logic fault, input logic mis);
    check_eq({tag, "_valid"}, resp_valid, 1'b1);
    check_eq({tag, "_rdata"}, resp_rdata, rdata);
    check_eq({tag, "_rd"}, resp_rd, rd);
    check_eq({tag, "_fault"}, resp_fault, fault);
    check_eq({tag, "_mis"}, resp_misaligned, mis);
    check_eq({tag, "_stall"}, stall, 1'b0);
    check_eq({tag, "_memreq"}, mem_req, 1'b0);
    step();
    check_eq({tag, "_one_pulse"}, resp_valid, 1'b0);
    check_eq({tag, "_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_func3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_fault", resp_fault, 1'b0);
    check_eq("rst_mis", resp_misaligned, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_rd", resp_rd, 5'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_mem_strb", mem_strb, 4'h0);

    // LB 0x103, zero wait: resp 2 cycles after acceptance
    issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd5);
    check_eq("lb_mem_addr", mem_addr, 32'h100);
    check_eq("lb_mem_strb", mem_strb, 4'hF);
    check_eq("lb_mem_we", mem_we, 1'b0);
    check_eq("lb_ready", req_ready, 1'b0);
    check_eq("lb_stall", stall, 1'b1);
    ack_after(0, 32'h80AB_CDEF);
    check_resp("lb", 32'hFFFF_FF80, 5'd5, 1'b0, 1'b0);

    // LHU 0x102
    issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd6);
    ack_after(0, 32'h80AB_CDEF);
    check_resp("lhu", 32'h0000_80AB, 5'd6, 1'b0, 1'b0);

    // LBU 0x101 with two wait states
    issue(1'b0, 3'b100, 32'h101, 32'h0, 5'd7);
    ack_after(2, 32'h80AB_CDEF);
    check_resp("lbu", 32'h0000_00CD, 5'd7, 1'b0, 1'b0);

    // LH 0x200 signed
    issue(1'b0, 3'b001, 32'h200, 32'h0, 5'd8);
    ack_after(1, 32'h1234_F00D);
    check_resp("lh", 32'hFFFF_F00D, 5'd8, 1'b0, 1'b0);

    // SB 0x101
    issue(1'b1, 3'b000, 32'h101, 32'h1234_56A5, 5'd9);
    check_eq("sb_strb", mem_strb, 4'b0010);
    check_eq("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check_eq("sb_addr", mem_addr, 32'h100);
    check_eq("sb_we", mem_we, 1'b1);
    ack_after(1, 32'hFFFF_FFFF);
    check_resp("sb", 32'h0, 5'd9, 1'b0, 1'b0);

    // SH 0x106
    issue(1'b1, 3'b001, 32'h106, 32'h0000_BEEF, 5'd10);
    check_eq("sh_strb", mem_strb, 4'b1100);
    check_eq("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    check_eq("sh_addr", mem_addr, 32'h104);
    ack_after(0, 32'h0);
    check_resp("sh", 32'h0, 5'd10, 1'b0, 1'b0);

    // LW 0x208
    issue(1'b0, 3'b010, 32'h208, 32'h0, 5'd11);
    check_eq("lw_addr", mem_addr, 32'h208);
    ack_after(0, 32'hCAFE_F00D);
    check_resp("lw", 32'hCAFE_F00D, 5'd11, 1'b0, 1'b0);

    // SW 0x102 misaligned: no memory access, resp next cycle
    issue(1'b1, 3'b010, 32'h102, 32'h1111_2222, 5'd12);
    check_resp("sw_mis", 32'h0, 5'd12, 1'b0, 1'b1);

    // LH 0x101 misaligned
    issue(1'b0, 3'b001, 32'h101, 32'h0, 5'd13);
    check_resp("lh_mis", 32'h0, 5'd13, 1'b0, 1'b1);

    // LD on XLEN=32: illegal
    issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd14);
    check_resp("ld_ill", 32'h0, 5'd14, 1'b1, 1'b0);

    // Store func3 100 is illegal; misaligned address must not flag mis
    issue(1'b1, 3'b100, 32'h103, 32'h0, 5'd15);
    check_resp("sbu_ill", 32'h0, 5'd15, 1'b1, 1'b0);

    // Load leaves non-zero rdata so the timeout clearing is visible
    issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd16);
    ack_after(0, 32'h5555_AAAA);
    check_resp("lw2", 32'h5555_AAAA, 5'd16, 1'b0, 1'b0);

    // Timeout: mem_req for exactly 4 cycles, then fault
    issue(1'b0, 3'b010, 32'h104, 32'h0, 5'd17);
    for (int i = 0; i < 4; i++) begin
      check_eq("to_mem_req", mem_req, 1'b1);
      check_eq("to_stall", stall, 1'b1);
      check_eq("to_no_resp", resp_valid, 1'b0);
      step();
    end
    check_resp("timeout", 32'h0, 5'd17, 1'b1, 1'b0);

    // rst during the 2nd ACCESS cycle of a LW with 3 wait states
    issue(1'b0, 3'b010, 32'h108, 32'h0, 5'd18);
    step();
    check_eq("rstacc_mem_req", mem_req, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rstacc_mem_req_low", mem_req, 1'b0);
    check_eq("rstacc_ready", req_ready, 1'b1);
    check_eq("rstacc_no_resp", resp_valid, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("late_ack_no_resp", resp_valid, 1'b0);
      check_eq("late_ack_no_req", mem_req, 1'b0);
      check_eq("late_ack_ready", req_ready, 1'b1);
      step();
    end

    // Normal operation after reset
    issue(1'b0, 3'b000, 32'h10C, 32'h0, 5'd19);
    ack_after(0, 32'h0000_007F);
    check_resp("lb_post", 32'h0000_007F, 5'd19, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
